control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Upstream control stage for the SAP-U datapath.
- Steps a T-state machine, decodes the 4-bit opcode held in the instruction register, and drives the per-cycle control word.
- The control word drives register A/B load and enable, ALU enable and subtract, RAM output-enable/write, the MAR load, the PC and the IR.
- Replaces the control inputs currently driven directly from the top-level ports.

Parameters:
- OPCODE_W, 4, opcode width; only 4 is supported.
- SKIP_IDLE, 0: 1 = return to T1 right after an instruction's last active T-state; 0 = always run T1..T6.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  advance enable; 0 freezes the state and holds the outputs.
- opcode  input  4  upper nibble of the IR; must be stable T4..T6.
- pc_enable  output  1  PC drives the bus.
- pc_inc  output  1  PC increment.
- pc_load  output  1  PC loads from the bus (JMP).
- mar_load  output  1  maps to ram_load_mar_reg.
- ram_output_enable  output  1  RAM drives the bus.
- ram_write  output  1  maps to ram_control_signal.
- ir_load  output  1  IR loads from the bus.
- ir_enable  output  1  IR operand nibble drives the bus.
- reg_a_load  output  1  A loads.
- reg_a_enable  output  1  A drives the bus.
- reg_b_load  output  1  B loads.
- alu_enable  output  1  ALU drives the bus.
- alu_subtract  output  1  ALU subtracts.
- out_load  output  1  output register loads.
- t_state  output  3  encoding: 0 IDLE, 1..6 = T1..T6, 7 HALT.
- halted  output  1  high in HALT.

Behaviour:
- Reset (reset=0, asynchronous, any state): t_state=IDLE, halted=0, every control output 0.
- IDLE: outputs 0; the first rising edge with run=1 enters T1.
- State advances only on a rising edge with run=1. With run=0 the state and all outputs hold.
- Control outputs are combinational from (t_state, opcode); no registered delay.
- Fetch, all opcodes:
  - T1: pc_enable, mar_load.
  - T2: pc_inc.
  - T3: ram_output_enable, ir_load.
- Execute, T4/T5/T6 (unlisted signals 0):
  - LDA 0x0: T4 ir_enable+mar_load; T5 ram_output_enable+reg_a_load; T6 none. Last active state T5.
  - ADD 0x1: T4 ir_enable+mar_load; T5 ram_output_enable+reg_b_load; T6 alu_enable+reg_a_load. Last active state T6.
  - SUB 0x2: same as ADD, plus alu_subtract in T6. Last active state T6.
  - STA 0x3: T4 ir_enable+mar_load; T5 reg_a_enable+ram_write; T6 none. Last active state T5.
  - JMP 0x4: T4 ir_enable+pc_load. Last active state T4.
  - OUT 0xE: T4 reg_a_enable+out_load. Last active state T4.
  - HLT 0xF: T4 all outputs 0; the next enabled edge goes to HALT.
  - Any other opcode is a NOP: T4..T6 all 0. Last active state T3.
- T6 goes to T1 on the next enabled edge.
- SKIP_IDLE=1: after the last active state the next enabled edge goes to T1; a NOP goes T3 to T1.
- HALT:
  - All control outputs 0, halted=1.
  - run and opcode are ignored.
  - Only reset leaves HALT.
- Reset asserted mid-instruction: outputs drop to 0 immediately, with no clock needed. The partially executed instruction is abandoned.
- Bus exclusivity: at most one of pc_enable, ram_output_enable, ir_enable, reg_a_enable, alu_enable is high in any state. The bench asserts this every cycle.

Decomposition:
- Shared package sap_u_pkg holds:
  - opcode constants: OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_JMP, OP_OUT, OP_HLT;
  - t_state encodings: ST_IDLE, ST_T1..ST_T6, ST_HALT;
  - control-word bit indices.
- One sub-module, control_decode: purely combinational map from (t_state, opcode) to the 14-bit control word.
- control_sequencer owns the state register, next-state logic, run gating and SKIP_IDLE.

Test Plan:
1. reset low for 2 cycles, run=1 -> t_state=0, all 14 outputs 0, halted=0. Release reset; first edge -> t_state=1, pc_enable=1, mar_load=1.
2. opcode=0x1 (ADD), SKIP_IDLE=0, run=1 for 6 edges -> t_state 1..6 with the exact words listed; T6 word alu_enable=1, reg_a_load=1, alu_subtract=0. Seventh edge -> t_state=1.
3. opcode=0x4 (JMP), SKIP_IDLE=1 -> sequence T1,T2,T3,T4 (ir_enable=1, pc_load=1), then T1. opcode=0x9 (NOP) -> T1,T2,T3,T1.
4. Mid-T5 of LDA (ram_output_enable=1, reg_a_load=1), drop run for 3 edges -> t_state stays 5, outputs unchanged. Raise run -> T6.
5. opcode=0xF -> T4 outputs 0, next edge t_state=7, halted=1. 10 further edges with run=1 and opcode=0x0 -> still 7. reset low -> t_state=0, halted=0.
6. Assert reset asynchronously between edges during STA T5 -> ram_write and reg_a_enable fall within the same cycle. Bus-exclusivity assertion holds for the whole run.

Source files
------------

// File: rtl/sap_u_pkg.sv
// Shared SAP-U control definitions: opcodes, T-state encodings, control-word bit positions.
// Zero latency (types and constants only); no flow control.
package sap_u_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } t_state_e;

    localparam int CW_W            = 14;
    localparam int CW_PC_ENABLE    = 13;
    localparam int CW_PC_INC       = 12;
    localparam int CW_PC_LOAD      = 11;
    localparam int CW_MAR_LOAD     = 10;
    localparam int CW_RAM_OE       = 9;
    localparam int CW_RAM_WRITE    = 8;
    localparam int CW_IR_LOAD      = 7;
    localparam int CW_IR_ENABLE    = 6;
    localparam int CW_REG_A_LOAD   = 5;
    localparam int CW_REG_A_ENABLE = 4;
    localparam int CW_REG_B_LOAD   = 3;
    localparam int CW_ALU_ENABLE   = 2;
    localparam int CW_ALU_SUBTRACT = 1;
    localparam int CW_OUT_LOAD     = 0;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Final T-state that does useful work; unknown opcodes finish with the fetch.
    function automatic t_state_e last_active_state(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:         return ST_T5;
            OP_ADD, OP_SUB:         return ST_T6;
            OP_JMP, OP_OUT, OP_HLT: return ST_T4;
            default:                return ST_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational map from (T-state, opcode) to the 14-bit SAP-U control word.
// Zero latency; no flow control.
module control_decode
    import sap_u_pkg::*;
(
    input  t_state_e   i_state,
    input  logic [3:0] i_opcode,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_T1: begin
                o_ctrl[CW_PC_ENABLE] = 1'b1;
                o_ctrl[CW_MAR_LOAD]  = 1'b1;
            end
            ST_T2: o_ctrl[CW_PC_INC] = 1'b1;
            ST_T3: begin
                o_ctrl[CW_RAM_OE]  = 1'b1;
                o_ctrl[CW_IR_LOAD] = 1'b1;
            end
            ST_T4: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_ctrl[CW_IR_ENABLE] = 1'b1;
                        o_ctrl[CW_MAR_LOAD]  = 1'b1;
                    end
                    OP_JMP: begin
                        o_ctrl[CW_IR_ENABLE] = 1'b1;
                        o_ctrl[CW_PC_LOAD]   = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl[CW_REG_A_ENABLE] = 1'b1;
                        o_ctrl[CW_OUT_LOAD]     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl[CW_RAM_OE]     = 1'b1;
                        o_ctrl[CW_REG_A_LOAD] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl[CW_RAM_OE]     = 1'b1;
                        o_ctrl[CW_REG_B_LOAD] = 1'b1;
                    end
                    OP_STA: begin
                        o_ctrl[CW_REG_A_ENABLE] = 1'b1;
                        o_ctrl[CW_RAM_WRITE]    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_ctrl[CW_ALU_ENABLE]   = 1'b1;
                    o_ctrl[CW_REG_A_LOAD]   = 1'b1;
                    o_ctrl[CW_ALU_SUBTRACT] = (i_opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP-U T-state sequencer: steps T1..T6/HALT on run, drives the decoded control word.
// Control outputs are combinational from the state register; run=0 freezes state and outputs.
module control_sequencer
    import sap_u_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter bit SKIP_IDLE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_enable,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_output_enable,
    output logic                ram_write,
    output logic                ir_load,
    output logic                ir_enable,
    output logic                reg_a_load,
    output logic                reg_a_enable,
    output logic                reg_b_load,
    output logic                alu_enable,
    output logic                alu_subtract,
    output logic                out_load,
    output logic [2:0]          t_state,
    output logic                halted
);

    t_state_e   r_state;
    t_state_e   w_next;
    t_state_e   w_last;
    ctrl_word_t w_ctrl;

    assign w_last = last_active_state(opcode);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = ST_T1;
            ST_T1:   w_next = ST_T2;
            ST_T2:   w_next = ST_T3;
            ST_T3:   w_next = (SKIP_IDLE && w_last == ST_T3) ? ST_T1 : ST_T4;
            ST_T4: begin
                // HLT parks in HALT whether or not idle T-states are skipped.
                if (opcode == OP_HLT)
                    w_next = ST_HALT;
                else if (SKIP_IDLE && w_last == ST_T4)
                    w_next = ST_T1;
                else
                    w_next = ST_T5;
            end
            ST_T5:   w_next = (SKIP_IDLE && w_last == ST_T5) ? ST_T1 : ST_T6;
            ST_T6:   w_next = ST_T1;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else if (run)
            r_state <= w_next;
    end

    control_decode u_decode (
        .i_state  (r_state),
        .i_opcode (opcode),
        .o_ctrl   (w_ctrl)
    );

    assign pc_enable         = w_ctrl[CW_PC_ENABLE];
    assign pc_inc            = w_ctrl[CW_PC_INC];
    assign pc_load           = w_ctrl[CW_PC_LOAD];
    assign mar_load          = w_ctrl[CW_MAR_LOAD];
    assign ram_output_enable = w_ctrl[CW_RAM_OE];
    assign ram_write         = w_ctrl[CW_RAM_WRITE];
    assign ir_load           = w_ctrl[CW_IR_LOAD];
    assign ir_enable         = w_ctrl[CW_IR_ENABLE];
    assign reg_a_load        = w_ctrl[CW_REG_A_LOAD];
    assign reg_a_enable      = w_ctrl[CW_REG_A_ENABLE];
    assign reg_b_load        = w_ctrl[CW_REG_B_LOAD];
    assign alu_enable        = w_ctrl[CW_ALU_ENABLE];
    assign alu_subtract      = w_ctrl[CW_ALU_SUBTRACT];
    assign out_load          = w_ctrl[CW_OUT_LOAD];

    assign t_state = r_state;
    assign halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: dut0 runs with SKIP_IDLE=0, dut1 with SKIP_IDLE=1.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b0, run0 = 1'b1, rst1 = 1'b0, run1 = 1'b1;
    logic [3:0] op0 = 4'h1, op1 = 4'h4;
    wire [13:0] cw0, cw1;
    wire [2:0]  ts0, ts1;
    wire        h0, h1;
    int         checks = 0;
    int         errors = 0;

    localparam logic [13:0] PCE  = 14'h2000, PCI = 14'h1000, PCL = 14'h0800, MARL = 14'h0400;
    localparam logic [13:0] ROE  = 14'h0200, RWR = 14'h0100, IRL = 14'h0080, IRE  = 14'h0040;
    localparam logic [13:0] RAL  = 14'h0020, RAE = 14'h0010, RBL = 14'h0008, ALE  = 14'h0004;
    localparam logic [13:0] ALS  = 14'h0002, OUTL = 14'h0001;
    localparam logic [13:0] BUS  = PCE | ROE | IRE | RAE | ALE;
    localparam logic [13:0] NONE = 14'h0000;

    control_sequencer #(.OPCODE_W(4), .SKIP_IDLE(1'b0)) dut0 (
        .clk(clk), .reset(rst0), .run(run0), .opcode(op0),
        .pc_enable(cw0[13]), .pc_inc(cw0[12]), .pc_load(cw0[11]), .mar_load(cw0[10]),
        .ram_output_enable(cw0[9]), .ram_write(cw0[8]), .ir_load(cw0[7]), .ir_enable(cw0[6]),
        .reg_a_load(cw0[5]), .reg_a_enable(cw0[4]), .reg_b_load(cw0[3]), .alu_enable(cw0[2]),
        .alu_subtract(cw0[1]), .out_load(cw0[0]), .t_state(ts0), .halted(h0)
    );

    control_sequencer #(.OPCODE_W(4), .SKIP_IDLE(1'b1)) dut1 (
        .clk(clk), .reset(rst1), .run(run1), .opcode(op1),
        .pc_enable(cw1[13]), .pc_inc(cw1[12]), .pc_load(cw1[11]), .mar_load(cw1[10]),
        .ram_output_enable(cw1[9]), .ram_write(cw1[8]), .ir_load(cw1[7]), .ir_enable(cw1[6]),
        .reg_a_load(cw1[5]), .reg_a_enable(cw1[4]), .reg_b_load(cw1[3]), .alu_enable(cw1[2]),
        .alu_subtract(cw1[1]), .out_load(cw1[0]), .t_state(ts1), .halted(h1)
    );

    typedef struct packed {
        logic        d;
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic [2:0]  st;
        logic [13:0] cw;
        logic        h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic d, input logic rst, input logic rn, input logic [3:0] op,
                       input logic [2:0] st, input logic [13:0] cw, input logic h);
        vec_t v;
        v.d = d; v.rst = rst; v.run = rn; v.op = op; v.st = st; v.cw = cw; v.h = h;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic d,
                         input logic [2:0] st, input logic [13:0] cw, input logic h);
        logic [2:0]  a_st;
        logic [13:0] a_cw;
        logic        a_h;
        a_st = d ? ts1 : ts0;
        a_cw = d ? cw1 : cw0;
        a_h  = d ? h1 : h0;
        checks++;
        if (a_st !== st || a_cw !== cw || a_h !== h) begin
            errors++;
            $display("FAIL %s[%0d] dut%0d: got t_state=%0d word=%h halted=%b, want t_state=%0d word=%h halted=%b",
                     name, idx, d, a_st, a_cw, a_h, st, cw, h);
        end
    endtask

    task automatic apply(input vec_t v);
        if (v.d) begin
            rst1 = v.rst; run1 = v.run; op1 = v.op; run0 = 1'b0;
        end else begin
            rst0 = v.rst; run0 = v.run; op0 = v.op; run1 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        checks++;
        if ($countones(cw0 & BUS) > 1) begin
            errors++;
            $display("FAIL bus_excl dut0: word=%h drives %0d bus sources, want at most 1", cw0, $countones(cw0 & BUS));
        end
        checks++;
        if ($countones(cw1 & BUS) > 1) begin
            errors++;
            $display("FAIL bus_excl dut1: word=%h drives %0d bus sources, want at most 1", cw1, $countones(cw1 & BUS));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // dut0, SKIP_IDLE=0: reset, ADD, SUB, LDA with run stall, STA, NOP, OUT
        add(0, 0, 1, 4'h1, 3'd0, NONE, 0);
        add(0, 0, 1, 4'h1, 3'd0, NONE, 0);
        add(0, 1, 1, 4'h1, 3'd1, PCE | MARL, 0);
        add(0, 1, 1, 4'h1, 3'd2, PCI, 0);
        add(0, 1, 1, 4'h1, 3'd3, ROE | IRL, 0);
        add(0, 1, 1, 4'h1, 3'd4, IRE | MARL, 0);
        add(0, 1, 1, 4'h1, 3'd5, ROE | RBL, 0);
        add(0, 1, 1, 4'h1, 3'd6, ALE | RAL, 0);
        add(0, 1, 1, 4'h1, 3'd1, PCE | MARL, 0);
        add(0, 1, 1, 4'h2, 3'd2, PCI, 0);
        add(0, 1, 1, 4'h2, 3'd3, ROE | IRL, 0);
        add(0, 1, 1, 4'h2, 3'd4, IRE | MARL, 0);
        add(0, 1, 1, 4'h2, 3'd5, ROE | RBL, 0);
        add(0, 1, 1, 4'h2, 3'd6, ALE | RAL | ALS, 0);
        add(0, 1, 1, 4'h2, 3'd1, PCE | MARL, 0);
        add(0, 1, 1, 4'h0, 3'd2, PCI, 0);
        add(0, 1, 1, 4'h0, 3'd3, ROE | IRL, 0);
        add(0, 1, 1, 4'h0, 3'd4, IRE | MARL, 0);
        add(0, 1, 1, 4'h0, 3'd5, ROE | RAL, 0);
        add(0, 1, 0, 4'h0, 3'd5, ROE | RAL, 0);
        add(0, 1, 0, 4'h0, 3'd5, ROE | RAL, 0);
        add(0, 1, 0, 4'h0, 3'd5, ROE | RAL, 0);
        add(0, 1, 1, 4'h0, 3'd6, NONE, 0);
        add(0, 1, 1, 4'h0, 3'd1, PCE | MARL, 0);
        add(0, 1, 1, 4'h3, 3'd2, PCI, 0);
        add(0, 1, 1, 4'h3, 3'd3, ROE | IRL, 0);
        add(0, 1, 1, 4'h3, 3'd4, IRE | MARL, 0);
        add(0, 1, 1, 4'h3, 3'd5, RAE | RWR, 0);
        add(0, 1, 1, 4'h3, 3'd6, NONE, 0);
        add(0, 1, 1, 4'h3, 3'd1, PCE | MARL, 0);
        add(0, 1, 1, 4'h9, 3'd2, PCI, 0);
        add(0, 1, 1, 4'h9, 3'd3, ROE | IRL, 0);
        add(0, 1, 1, 4'h9, 3'd4, NONE, 0);
        add(0, 1, 1, 4'h9, 3'd5, NONE, 0);
        add(0, 1, 1, 4'h9, 3'd6, NONE, 0);
        add(0, 1, 1, 4'h9, 3'd1, PCE | MARL, 0);
        add(0, 1, 1, 4'hE, 3'd2, PCI, 0);
        add(0, 1, 1, 4'hE, 3'd3, ROE | IRL, 0);
        add(0, 1, 1, 4'hE, 3'd4, RAE | OUTL, 0);
        add(0, 1, 1, 4'hE, 3'd5, NONE, 0);
        add(0, 1, 1, 4'hE, 3'd6, NONE, 0);
        add(0, 1, 1, 4'hE, 3'd1, PCE | MARL, 0);
        // dut1, SKIP_IDLE=1: JMP, NOP, LDA, OUT, STA, SUB, then HLT
        add(1, 0, 1, 4'h4, 3'd0, NONE, 0);
        add(1, 1, 1, 4'h4, 3'd1, PCE | MARL, 0);
        add(1, 1, 1, 4'h4, 3'd2, PCI, 0);
        add(1, 1, 1, 4'h4, 3'd3, ROE | IRL, 0);
        add(1, 1, 1, 4'h4, 3'd4, IRE | PCL, 0);
        add(1, 1, 1, 4'h4, 3'd1, PCE | MARL, 0);
        add(1, 1, 1, 4'h9, 3'd2, PCI, 0);
        add(1, 1, 1, 4'h9, 3'd3, ROE | IRL, 0);
        add(1, 1, 1, 4'h9, 3'd1, PCE | MARL, 0);
        add(1, 1, 1, 4'h0, 3'd2, PCI, 0);
        add(1, 1, 1, 4'h0, 3'd3, ROE | IRL, 0);
        add(1, 1, 1, 4'h0, 3'd4, IRE | MARL, 0);
        add(1, 1, 1, 4'h0, 3'd5, ROE | RAL, 0);
        add(1, 1, 1, 4'h0, 3'd1, PCE | MARL, 0);
        add(1, 1, 1, 4'hE, 3'd2, PCI, 0);
        add(1, 1, 1, 4'hE, 3'd3, ROE | IRL, 0);
        add(1, 1, 1, 4'hE, 3'd4, RAE | OUTL, 0);
        add(1, 1, 1, 4'hE, 3'd1, PCE | MARL, 0);
        add(1, 1, 1, 4'h3, 3'd2, PCI, 0);
        add(1, 1, 1, 4'h3, 3'd3, ROE | IRL, 0);
        add(1, 1, 1, 4'h3, 3'd4, IRE | MARL, 0);
        add(1, 1, 1, 4'h3, 3'd5, RAE | RWR, 0);
        add(1, 1, 1, 4'h3, 3'd1, PCE | MARL, 0);
        add(1, 1, 1, 4'h2, 3'd2, PCI, 0);
        add(1, 1, 1, 4'h2, 3'd3, ROE | IRL, 0);
        add(1, 1, 1, 4'h2, 3'd4, IRE | MARL, 0);
        add(1, 1, 1, 4'h2, 3'd5, ROE | RBL, 0);
        add(1, 1, 1, 4'h2, 3'd6, ALE | RAL | ALS, 0);
        add(1, 1, 1, 4'h2, 3'd1, PCE | MARL, 0);
        add(1, 1, 1, 4'hF, 3'd2, PCI, 0);
        add(1, 1, 1, 4'hF, 3'd3, ROE | IRL, 0);
        add(1, 1, 1, 4'hF, 3'd4, NONE, 0);
        add(1, 1, 1, 4'hF, 3'd7, NONE, 1);

        foreach (tbl[i]) begin
            apply(tbl[i]);
            check("vec", i, tbl[i].d, tbl[i].st, tbl[i].cw, tbl[i].h);
        end

        // HALT ignores run and opcode; only reset leaves it
        op1 = 4'h0;
        run1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("halt_hold", k, 1'b1, 3'd7, NONE, 1'b1);
        end
        #2;
        rst1 = 1'b0;
        #1;
        check("halt_async_rst", 0, 1'b1, 3'd0, NONE, 1'b0);
        @(posedge clk);
        #1;
        rst1 = 1'b1;
        run1 = 1'b0;
        @(posedge clk);
        #1;
        check("halt_rst_frozen", 0, 1'b1, 3'd0, NONE, 1'b0);

        // Async reset between edges while STA is in T5
        op0 = 4'h3;
        run0 = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk);
            #1;
            case (k)
                2:       check("sta_walk", k, 1'b0, 3'd2, PCI, 1'b0);
                3:       check("sta_walk", k, 1'b0, 3'd3, ROE | IRL, 1'b0);
                4:       check("sta_walk", k, 1'b0, 3'd4, IRE | MARL, 1'b0);
                default: check("sta_walk", k, 1'b0, 3'd5, RAE | RWR, 1'b0);
            endcase
        end
        #2;
        rst0 = 1'b0;
        #1;
        check("sta_async_rst", 0, 1'b0, 3'd0, NONE, 1'b0);
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_t1", 0, 1'b0, 3'd1, PCE | MARL, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
